// File: rtl/bsg_parallel_in_serial_out_masked.sv
// bsg_parallel_in_serial_out_masked: unpacks masked els_p-lane words into a one-lane-per-beat valid/yumi stream.
// Define BSG_PISO_MASKED_LAST_EN to add last_o, which marks the final beat of each word.
module bsg_parallel_in_serial_out_masked #(
  parameter int width_p = 128,
  parameter int els_p   = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         mask_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i
`ifdef BSG_PISO_MASKED_LAST_EN
  ,
  output logic                     last_o
`endif
);
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  state_e state_r, state_n;
  logic [els_p-1:0][width_p-1:0] act_data_r, pend_data_r;
  logic [els_p-1:0] act_mask_r, pend_mask_r, rem_mask;
  logic [lg_els_lp-1:0] sel;
  logic accept, yumi_ok, retire;
  // an all-zero mask is taken off the input but never stored
  assign accept  = v_i & ready_o & |mask_i;
  assign yumi_ok = yumi_i & v_o;
  assign rem_mask = act_mask_r & (act_mask_r - els_p'(1));
  assign retire  = yumi_ok & ~|rem_mask;
  always_comb begin
    sel = '0;
    for (int i = els_p - 1; i >= 0; i--) if (act_mask_r[i]) sel = lg_els_lp'(i);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= EMPTY;
    else state_r <= state_n;
  always_comb begin
    state_n = state_r;
    case (state_r)
      EMPTY:   state_n = accept ? ONE : EMPTY;
      ONE:     state_n = accept ? (retire ? ONE : TWO) : (retire ? EMPTY : ONE);
      TWO:     state_n = retire ? ONE : TWO;
      default: state_n = EMPTY;
    endcase
  end
  always_comb begin
    ready_o = state_r != TWO;
    v_o     = state_r != EMPTY;
    data_o  = act_data_r[sel];
  end
`ifdef BSG_PISO_MASKED_LAST_EN
  assign last_o = v_o & ~|rem_mask;
`endif
  // a new word lands in active when the active slot is empty or retiring this cycle
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      act_data_r  <= '0;
      act_mask_r  <= '0;
      pend_data_r <= '0;
      pend_mask_r <= '0;
    end else begin
      if (accept && (state_r == EMPTY || retire)) begin
        act_data_r <= data_i;
        act_mask_r <= mask_i;
      end else if (retire && state_r == TWO) begin
        act_data_r <= pend_data_r;
        act_mask_r <= pend_mask_r;
      end else if (yumi_ok) act_mask_r <= rem_mask;
      if (accept && state_r == ONE && !retire) begin
        pend_data_r <= data_i;
        pend_mask_r <= mask_i;
      end
    end
  always_ff @(posedge clk_i)
    if (reset_n_i) assert (!(yumi_i && !v_o)) else $warning("yumi_i asserted while v_o low, ignored");
endmodule

// File: tb/tb_bsg_parallel_in_serial_out_masked.sv
// tb_bsg_parallel_in_serial_out_masked: directed and random checks against a beat-queue reference model.
module tb_bsg_parallel_in_serial_out_masked;
  localparam int W = 32, E = 2;
  logic clk_i = 0, reset_n_i = 0, v_i = 0, yumi_i = 0;
  logic [E*W-1:0] data_i = '0;
  logic [E-1:0] mask_i = '0;
  logic ready_o, v_o;
  logic [W-1:0] data_o;
`ifdef BSG_PISO_MASKED_LAST_EN
  logic last_o;
`endif
  int tests = 0, fails = 0;
  typedef struct {logic [W-1:0] d; logic l;} beat_t;
  beat_t bq[$];
  always #5 clk_i = ~clk_i;

  bsg_parallel_in_serial_out_masked #(.width_p(W), .els_p(E)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .mask_i(mask_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
`ifdef BSG_PISO_MASKED_LAST_EN
    , .last_o(last_o)
`endif
  );

  function automatic int words_held();
    int n = 0;
    foreach (bq[i]) n += int'(bq[i].l);
    return n;
  endfunction

  // advance one clock; the model queues each accepted word's set lanes, lowest index first
  task automatic tick();
    logic fin = v_i & ready_o, fout = yumi_i & v_o;
    logic [E*W-1:0] d = data_i;
    logic [E-1:0] m = mask_i;
    int hi = -1;
    @(posedge clk_i);
    if (fout && bq.size() != 0) void'(bq.pop_front());
    if (fin) begin
      for (int k = 0; k < E; k++) if (m[k]) hi = k;
      for (int k = 0; k < E; k++) if (m[k]) bq.push_back('{d[k*W +: W], k == hi});
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL reset v_o got %b exp 0", v_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset ready_o got %b exp 1", ready_o); end
    tests++; if (data_o !== '0) begin fails++; $display("FAIL reset data_o got %h exp 0", data_o); end
`ifdef BSG_PISO_MASKED_LAST_EN
    tests++; if (last_o !== 1'b0) begin fails++; $display("FAIL reset last_o got %b exp 0", last_o); end
`endif
    reset_n_i = 1;
    bq.delete();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_single();
    logic [W-1:0] a = 32'hA5A5_0001, b = 32'h5A5A_0002;
    v_i = 1; mask_i = 2'b11; data_i = {b, a}; yumi_i = 1;
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL single ready_o got %b exp 1", ready_o); end
    tick();
    v_i = 0;
    for (int c = 0; c < 2; c++) begin
      tests++; if (v_o !== 1'b1) begin fails++; $display("FAIL single v_o beat%0d got %b exp 1", c, v_o); end
      tests++; if (data_o !== (c == 0 ? a : b)) begin fails++; $display("FAIL single data beat%0d got %h exp %h", c, data_o, c == 0 ? a : b); end
`ifdef BSG_PISO_MASKED_LAST_EN
      tests++; if (last_o !== (c == 1)) begin fails++; $display("FAIL single last beat%0d got %b exp %b", c, last_o, c == 1); end
`endif
      tick();
    end
    yumi_i = 0;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL single v_o after got %b exp 0", v_o); end
    bq.delete();
  endtask

  task automatic test_stream();
    logic [E*W-1:0] w[4];
    int sent = 0, beats = 0, first = -1, lastc = -1;
    logic acc;
    foreach (w[i]) w[i] = {$urandom, $urandom};
    mask_i = 2'b11;
    for (int c = 0; c < 14; c++) begin
      v_i = sent < 4; data_i = w[sent % 4]; yumi_i = v_o;
      tests++; if (v_o !== (bq.size() != 0)) begin fails++; $display("FAIL stream v_o c%0d got %b exp %b", c, v_o, bq.size() != 0); end
      if (bq.size() != 0) begin
        tests++; if (data_o !== bq[0].d) begin fails++; $display("FAIL stream data c%0d got %h exp %h", c, data_o, bq[0].d); end
      end
      if (v_o) begin beats++; if (first < 0) first = c; lastc = c; end
      acc = v_i & ready_o;
      tick();
      if (acc) sent++;
    end
    v_i = 0; yumi_i = 0;
    tests++; if (beats != 8) begin fails++; $display("FAIL stream beat count got %0d exp 8", beats); end
    tests++; if (lastc - first != 7) begin fails++; $display("FAIL stream span got %0d exp 7", lastc - first); end
  endtask

  task automatic test_backpressure();
    logic [E*W-1:0] w[3];
    bit exp_r[6] = '{1, 1, 0, 0, 0, 1};
    bit ysch[6] = '{0, 0, 0, 1, 1, 0};
    int nacc = 0;
    logic acc;
    foreach (w[i]) w[i] = {$urandom, $urandom};
    mask_i = 2'b11;
    for (int c = 0; c < 6; c++) begin
      v_i = nacc < 3; data_i = w[nacc % 3]; yumi_i = ysch[c] & v_o;
      tests++; if (ready_o !== exp_r[c]) begin fails++; $display("FAIL backpressure ready c%0d got %b exp %b", c, ready_o, exp_r[c]); end
      if (bq.size() != 0) begin
        tests++; if (data_o !== bq[0].d) begin fails++; $display("FAIL backpressure data c%0d got %h exp %h", c, data_o, bq[0].d); end
      end
      acc = v_i & ready_o;
      tick();
      if (acc) nacc++;
    end
    v_i = 0;
    for (int c = 0; c < 10; c++) begin
      yumi_i = v_o;
      if (bq.size() != 0) begin
        tests++; if (data_o !== bq[0].d) begin fails++; $display("FAIL backpressure drain data got %h exp %h", data_o, bq[0].d); end
      end
      tick();
    end
    yumi_i = 0;
    tests++; if (nacc != 3 || v_o !== 1'b0 || bq.size() != 0) begin fails++; $display("FAIL backpressure end accepted %0d v_o %b left %0d exp 3 0 0", nacc, v_o, bq.size()); end
  endtask

  task automatic test_masks();
    logic [W-1:0] x = 32'h0000_00A1, y = 32'h0000_00B2, p = 32'h0000_00C3, q = 32'h0000_00D4;
    logic [E*W-1:0] wd[3];
    logic [E-1:0] wm[3] = '{2'b10, 2'b00, 2'b01};
    logic [W-1:0] obs[$];
    int idx = 0;
    logic acc;
    wd[0] = {y, x}; wd[1] = {$urandom, $urandom}; wd[2] = {q, p};
    for (int c = 0; c < 8; c++) begin
      v_i = idx < 3; data_i = wd[idx % 3]; mask_i = wm[idx % 3]; yumi_i = v_o;
      tests++; if (v_o !== (bq.size() != 0)) begin fails++; $display("FAIL masks v_o c%0d got %b exp %b", c, v_o, bq.size() != 0); end
`ifdef BSG_PISO_MASKED_LAST_EN
      if (bq.size() != 0) begin
        tests++; if (last_o !== bq[0].l) begin fails++; $display("FAIL masks last c%0d got %b exp %b", c, last_o, bq[0].l); end
      end
`endif
      if (v_o) obs.push_back(data_o);
      acc = v_i & ready_o;
      tick();
      if (acc) idx++;
    end
    v_i = 0; yumi_i = 0;
    tests++; if (obs.size() != 2) begin fails++; $display("FAIL masks beat count got %0d exp 2", obs.size()); end
    else begin
      tests++; if (obs[0] !== y || obs[1] !== p) begin fails++; $display("FAIL masks beats got %h %h exp %h %h", obs[0], obs[1], y, p); end
    end
  endtask

  task automatic test_reset_mid();
    v_i = 1; mask_i = 2'b11; data_i = {$urandom, $urandom}; yumi_i = 0;
    tick();
    v_i = 0; yumi_i = v_o;
    tick();
    yumi_i = 0;
    #2 reset_n_i = 0;
    #1;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL reset_mid v_o got %b exp 0", v_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_mid ready_o got %b exp 1", ready_o); end
    #1 reset_n_i = 1;
    bq.delete();
    for (int c = 0; c < 4; c++) begin
      tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL reset_mid residual c%0d v_o got %b exp 0", c, v_o); end
      tick();
    end
  endtask

  task automatic test_protocol();
    logic [W-1:0] p = 32'h1234_5678;
    v_i = 0; yumi_i = 1;
    tick();
    yumi_i = 0;
    tests++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin fails++; $display("FAIL protocol state v_o %b ready %b exp 0 1", v_o, ready_o); end
    v_i = 1; mask_i = 2'b01; data_i = {32'hFFFF_FFFF, p};
    tick();
    v_i = 0; yumi_i = v_o;
    tests++; if (v_o !== 1'b1 || data_o !== p) begin fails++; $display("FAIL protocol beat v_o %b data %h exp 1 %h", v_o, data_o, p); end
    tick();
    yumi_i = 0;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL protocol after v_o got %b exp 0", v_o); end
    bq.delete();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      v_i = $urandom_range(0, 1); data_i = {$urandom, $urandom}; mask_i = E'($urandom);
      yumi_i = v_o & ($urandom_range(0, 3) != 0);
      tests++; if (v_o !== (bq.size() != 0)) begin fails++; $display("FAIL random v_o c%0d got %b exp %b", c, v_o, bq.size() != 0); end
      tests++; if (ready_o !== (words_held() < 2)) begin fails++; $display("FAIL random ready c%0d got %b exp %b", c, ready_o, words_held() < 2); end
      if (bq.size() != 0) begin
        tests++; if (data_o !== bq[0].d) begin fails++; $display("FAIL random data c%0d got %h exp %h", c, data_o, bq[0].d); end
`ifdef BSG_PISO_MASKED_LAST_EN
        tests++; if (last_o !== bq[0].l) begin fails++; $display("FAIL random last c%0d got %b exp %b", c, last_o, bq[0].l); end
`endif
      end
      tick();
    end
    v_i = 0;
    for (int c = 0; c < 8; c++) begin
      yumi_i = v_o;
      tick();
    end
    yumi_i = 0;
    tests++; if (v_o !== 1'b0 || bq.size() != 0) begin fails++; $display("FAIL random drain v_o %b left %0d exp 0 0", v_o, bq.size()); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_masks();
    test_reset_mid();
    test_protocol();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end
endmodule
